// File: rtl/rx_pause_ctrl.sv
// Receive-side PAUSE scheduler: captures pause_quanta for flagged PAUSE frames and
// runs the transmit pause handshake plus the quanta timer on the 64-bit rxclk datapath.
module rx_pause_ctrl #(
  parameter int QUANTA_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             pause_enable,
  input  logic             pause_frame,
  input  logic             pause_quanta_vld,
  input  logic [CNT_W-1:0] pause_quanta,
  input  logic             good_frame_get,
  input  logic             bad_frame_get,
  input  logic             tx_pause_ack,
  output logic             tx_pause_req,
  output logic             pause_active,
  output logic [CNT_W-1:0] quanta_remaining,
  output logic             pause_cnt_inc
);

  // Handshake: tx_pause_req is a level held until the pause ends; tx_pause_ack is a level
  // sampled only in REQ, meaning the transmitter has drained its current frame and is idle.

  localparam logic [7:0]       PRESC_LOAD = 8'(QUANTA_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, PAUSED} state_t;

  state_t           state;
  logic             pending;
  logic [CNT_W-1:0] cap_q;
  logic [CNT_W-1:0] timer;
  logic [7:0]       presc;

  logic good_ok;
  logic upd;
  logic upd_nz;

  // A simultaneous good+bad verdict is treated as bad.
  assign good_ok = good_frame_get & ~bad_frame_get;
  assign upd     = good_ok & pending & pause_enable;
  assign upd_nz  = upd & (cap_q != '0);

  assign quanta_remaining = timer;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      cap_q   <= '0;
    end else if (!pause_enable) begin
      pending <= 1'b0;
    end else begin
      if (pending && pause_quanta_vld)
        cap_q <= pause_quanta;
      // A new PAUSE frame wins over a verdict: the verdict closes the old frame.
      if (pause_frame) begin
        pending <= 1'b1;
        cap_q   <= '0;
      end else if (good_frame_get || bad_frame_get) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset)
      pause_cnt_inc <= 1'b0;
    else
      pause_cnt_inc <= upd;
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      presc        <= '0;
      tx_pause_req <= 1'b0;
      pause_active <= 1'b0;
    end else if (!pause_enable) begin
      state        <= IDLE;
      timer        <= '0;
      presc        <= '0;
      tx_pause_req <= 1'b0;
      pause_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_nz) begin
            state        <= REQ;
            timer        <= cap_q;
            tx_pause_req <= 1'b1;
          end
        end
        REQ: begin
          if (upd) begin
            if (upd_nz) begin
              timer <= cap_q;
            end else begin
              state        <= IDLE;
              timer        <= '0;
              tx_pause_req <= 1'b0;
            end
          end else if (tx_pause_ack) begin
            state        <= PAUSED;
            presc        <= PRESC_LOAD;
            pause_active <= 1'b1;
          end
        end
        PAUSED: begin
          if (upd) begin
            if (upd_nz) begin
              timer <= cap_q;
              presc <= PRESC_LOAD;
            end else begin
              state        <= IDLE;
              timer        <= '0;
              presc        <= '0;
              tx_pause_req <= 1'b0;
              pause_active <= 1'b0;
            end
          end else if (presc != '0) begin
            presc <= presc - 8'd1;
          end else if (timer == ONE) begin
            // Timer is only ever loaded non-zero here, so it cannot wrap.
            state        <= IDLE;
            timer        <= '0;
            tx_pause_req <= 1'b0;
            pause_active <= 1'b0;
          end else begin
            presc <= PRESC_LOAD;
            timer <= timer - ONE;
          end
        end
        default: begin
          state        <= IDLE;
          timer        <= '0;
          presc        <= '0;
          tx_pause_req <= 1'b0;
          pause_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pause_ctrl.sv
// Bench for rx_pause_ctrl: a QUANTA_CYCLES=8 instance plus a QUANTA_CYCLES=2 instance
// sharing stimulus; expectations are queued per cycle and compared as outputs appear.
module tb_rx_pause_ctrl;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic        pause_enable = 1'b1;
  logic        pause_frame = 1'b0;
  logic        pause_quanta_vld = 1'b0;
  logic [15:0] pause_quanta = '0;
  logic        good_frame_get = 1'b0;
  logic        bad_frame_get = 1'b0;
  logic        tx_pause_ack = 1'b0;

  logic        tx_pause_req, pause_active, pause_cnt_inc;
  logic [15:0] quanta_remaining;
  logic        tx_pause_req2, pause_active2, pause_cnt_inc2;
  logic [15:0] quanta_remaining2;

  logic [18:0] obs, obs2;
  assign obs  = {tx_pause_req, pause_active, pause_cnt_inc, quanta_remaining};
  assign obs2 = {tx_pause_req2, pause_active2, pause_cnt_inc2, quanta_remaining2};

  logic [18:0] exp_q[$];
  logic [18:0] e;
  int checks = 0;
  int failures = 0;

  rx_pause_ctrl #(.QUANTA_CYCLES(8), .CNT_W(16)) dut (
    .rxclk(rxclk), .reset(reset), .pause_enable(pause_enable), .pause_frame(pause_frame),
    .pause_quanta_vld(pause_quanta_vld), .pause_quanta(pause_quanta),
    .good_frame_get(good_frame_get), .bad_frame_get(bad_frame_get), .tx_pause_ack(tx_pause_ack),
    .tx_pause_req(tx_pause_req), .pause_active(pause_active),
    .quanta_remaining(quanta_remaining), .pause_cnt_inc(pause_cnt_inc)
  );

  rx_pause_ctrl #(.QUANTA_CYCLES(2), .CNT_W(16)) dut2 (
    .rxclk(rxclk), .reset(reset), .pause_enable(pause_enable), .pause_frame(pause_frame),
    .pause_quanta_vld(pause_quanta_vld), .pause_quanta(pause_quanta),
    .good_frame_get(good_frame_get), .bad_frame_get(bad_frame_get), .tx_pause_ack(tx_pause_ack),
    .tx_pause_req(tx_pause_req2), .pause_active(pause_active2),
    .quanta_remaining(quanta_remaining2), .pause_cnt_inc(pause_cnt_inc2)
  );

  always #5 rxclk = ~rxclk;

  // Advance one edge; inputs set after return are sampled on the next edge.
  task automatic clk1();
    @(posedge rxclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // PAUSE frame flag, quanta, then verdict on three consecutive edges.
  task automatic send_pause(input logic [15:0] q, input logic good, input logic bad);
    pause_frame = 1'b1;
    clk1();
    pause_frame = 1'b0;
    pause_quanta_vld = 1'b1;
    pause_quanta = q;
    clk1();
    pause_quanta_vld = 1'b0;
    good_frame_get = good;
    bad_frame_get = bad;
    clk1();
    good_frame_get = 1'b0;
    bad_frame_get = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge rxclk);
    #1;
    checks++;
    if (obs !== 19'h0) begin
      failures++;
      $display("FAIL reset_main got=%h exp=%h", obs, 19'h0);
    end
    checks++;
    if (obs2 !== 19'h0) begin
      failures++;
      $display("FAIL reset_qc2 got=%h exp=%h", obs2, 19'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_good_q3();
    int extra_inc;
    do_reset();
    send_pause(16'd3, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 1'b1, 16'd3});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL q3_req_rise got=%h exp=%h", obs, e); end
    clk1();
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'd3});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL q3_req_hold got=%h exp=%h", obs, e); end
    tx_pause_ack = 1'b1;
    clk1();
    tx_pause_ack = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'd3});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL q3_paused got=%h exp=%h", obs, e); end
    extra_inc = 0;
    for (int k = 1; k <= 24; k++) begin
      clk1();
      if (k < 24) exp_q.push_back({1'b1, 1'b1, 1'b0, 16'(3 - k / 8)});
      else exp_q.push_back(19'h0);
      e = exp_q.pop_front();
      extra_inc += int'(pause_cnt_inc);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL q3_trace k=%0d got=%h exp=%h", k, obs, e); end
    end
    checks++;
    if (extra_inc !== 0) begin
      failures++;
      $display("FAIL q3_single_inc got=%0d exp=%0d", extra_inc, 0);
    end
  endtask

  task automatic test_bad();
    do_reset();
    send_pause(16'd7, 1'b0, 1'b1);
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL bad_verdict got=%h exp=%h", obs, 19'h0); end
    clk1();
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL bad_after got=%h exp=%h", obs, 19'h0); end
    send_pause(16'd7, 1'b1, 1'b1);
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL goodbad_verdict got=%h exp=%h", obs, 19'h0); end
    clk1();
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL goodbad_after got=%h exp=%h", obs, 19'h0); end
  endtask

  task automatic test_xon_and_reload();
    do_reset();
    send_pause(16'd2, 1'b1, 1'b0);
    tx_pause_ack = 1'b1;
    clk1();
    tx_pause_ack = 1'b0;
    checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 16'd2}) begin
      failures++;
      $display("FAIL xon_pre got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 16'd2});
    end
    send_pause(16'd0, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 16'd0});
    e = exp_q.pop_front();
    checks++;
    if (obs[18:16] !== e[18:16]) begin
      failures++;
      $display("FAIL xon_idle got=%b exp=%b", obs[18:16], e[18:16]);
    end
    do_reset();
    send_pause(16'd2, 1'b1, 1'b0);
    tx_pause_ack = 1'b1;
    clk1();
    tx_pause_ack = 1'b0;
    send_pause(16'd5, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 1'b1, 1'b1, 16'd5});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reload_5 got=%h exp=%h", obs, e); end
    for (int k = 1; k <= 40; k++) begin
      clk1();
      if (k < 40) exp_q.push_back({1'b1, 1'b1, 1'b0, 16'(5 - k / 8)});
      else exp_q.push_back(19'h0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL reload_trace k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_capture();
    do_reset();
    pause_quanta = 16'd9;
    pause_quanta_vld = 1'b1;
    clk1();
    pause_quanta_vld = 1'b0;
    good_frame_get = 1'b1;
    clk1();
    good_frame_get = 1'b0;
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL orphan_vld got=%h exp=%h", obs, 19'h0); end
    pause_frame = 1'b1;
    clk1();
    pause_frame = 1'b0;
    good_frame_get = 1'b1;
    clk1();
    good_frame_get = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL q0_in_idle got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 16'd0});
    end
    pause_frame = 1'b1;
    clk1();
    pause_frame = 1'b0;
    pause_quanta_vld = 1'b1;
    pause_quanta = 16'd4;
    clk1();
    pause_quanta_vld = 1'b0;
    pause_frame = 1'b1;
    good_frame_get = 1'b1;
    clk1();
    pause_frame = 1'b0;
    good_frame_get = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 1'b1, 16'd4});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL frame_and_verdict got=%h exp=%h", obs, e); end
    pause_quanta_vld = 1'b1;
    pause_quanta = 16'd6;
    clk1();
    pause_quanta_vld = 1'b0;
    good_frame_get = 1'b1;
    clk1();
    good_frame_get = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 1'b1, 16'd6});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL new_frame_pending got=%h exp=%h", obs, e); end
  endtask

  task automatic test_enable_and_async_reset();
    do_reset();
    send_pause(16'hFFFF, 1'b1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 16'hFFFF}) begin
      failures++;
      $display("FAIL max_q got=%h exp=%h", obs, {1'b1, 1'b0, 1'b1, 16'hFFFF});
    end
    tx_pause_ack = 1'b1;
    clk1();
    tx_pause_ack = 1'b0;
    repeat (20) clk1();
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'hFFFD});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL max_countdown got=%h exp=%h", obs, e); end
    pause_enable = 1'b0;
    clk1();
    checks++;
    if (obs !== 19'h0) begin failures++; $display("FAIL enable_off got=%h exp=%h", obs, 19'h0); end
    pause_enable = 1'b1;
    clk1();
    send_pause(16'd5, 1'b1, 1'b0);
    checks++;
    if (tx_pause_req !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%b exp=%b", tx_pause_req, 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx_pause_req !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_req got=%b exp=%b", tx_pause_req, 1'b0);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_qc2();
    do_reset();
    send_pause(16'd1, 1'b1, 1'b0);
    checks++;
    if (obs2 !== {1'b1, 1'b0, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL qc2_req got=%h exp=%h", obs2, {1'b1, 1'b0, 1'b1, 16'd1});
    end
    tx_pause_ack = 1'b1;
    clk1();
    tx_pause_ack = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'd1});
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'd1});
    exp_q.push_back(19'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) clk1();
      e = exp_q.pop_front();
      checks++;
      if (obs2 !== e) begin failures++; $display("FAIL qc2_trace k=%0d got=%h exp=%h", k, obs2, e); end
    end
  endtask

  initial begin
    test_reset();
    test_good_q3();
    test_bad();
    test_xon_and_reload();
    test_capture();
    test_enable_and_async_reset();
    test_qc2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_pause_ctrl.md
Name: rx_pause_ctrl

Overview:
Receive-side PAUSE scheduler for the 10G MAC. It captures the pause_quanta field of MAC-control PAUSE frames flagged by the receive datapath and holds it until the frame's good/bad verdict arrives. It then sequences the transmit side through a pause request/acknowledge handshake and times the pause in 512-bit quanta on the 64-bit rxclk datapath. It also reports the live quanta count and a per-accepted-PAUSE statistic pulse.

Parameters:
QUANTA_CYCLES, 8, rxclk cycles per pause quantum (512 bit times / 64 bits per cycle); legal range 2..255
CNT_W, 16, width of the pause quanta timer

Ports:
rxclk  input  1  receive clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
pause_enable  input  1  PAUSE honouring enable, static configuration bit
pause_frame  input  1  one-cycle pulse: current frame is a PAUSE frame
pause_quanta_vld  input  1  one-cycle pulse: pause_quanta is valid for the current frame
pause_quanta  input  CNT_W  pause_quanta field, big-endian decoded
good_frame_get  input  1  one-cycle pulse: current frame passed all checks
bad_frame_get  input  1  one-cycle pulse: current frame failed
tx_pause_ack  input  1  level: transmitter has finished its current frame and is idle
tx_pause_req  output  1  level: transmitter must stop after its current frame
pause_active  output  1  high while the pause timer is counting
quanta_remaining  output  CNT_W  current timer value
pause_cnt_inc  output  1  one-cycle pulse per accepted PAUSE frame

Behaviour:
- Reset (async): all outputs 0; state IDLE; pending=0; captured quanta=0; prescaler=0; timer=0. A reset mid-pause drops tx_pause_req immediately.
- Capture unit:
  - pause_frame sets pending=1 and clears captured quanta.
  - pause_quanta_vld while pending stores pause_quanta. With pending=0 it is ignored.
  - good_frame_get or bad_frame_get clears pending. With pending=0 either verdict is ignored.
  - good and bad asserted together count as bad.
  - If pause_frame and a verdict arrive in the same cycle, the verdict applies to the old frame and the new frame becomes pending.
- Update event U(q): good_frame_get with pending=1 and pause_enable=1, where q is the captured quanta. pause_cnt_inc pulses in the cycle after U. A bad verdict produces no event and no pulse.
- FSM states: IDLE, REQ, PAUSED.
  - IDLE: U(q>0) moves to REQ and loads timer=q. U(0) is ignored. tx_pause_req=0.
  - REQ: tx_pause_req=1 and the timer is frozen.
    - tx_pause_ack=1 moves to PAUSED and loads prescaler=QUANTA_CYCLES-1.
    - U(q>0) reloads timer=q and stays in REQ.
    - U(0) moves to IDLE.
    - If U and ack occur together, U has priority.
  - PAUSED: tx_pause_req=1, pause_active=1.
    - Each cycle: if prescaler!=0, prescaler-1; otherwise prescaler reloads and timer-1.
    - When timer==1 and prescaler==0, go to IDLE with timer=0.
    - U(q>0) reloads timer=q and prescaler=QUANTA_CYCLES-1. U(0) goes to IDLE.
    - tx_pause_ack is ignored in PAUSED.
- pause_enable=0 forces IDLE from any state on the next edge and clears pending, timer and prescaler.
- Latency and duration:
  - tx_pause_req rises in the cycle after good_frame_get.
  - If ack is sampled at edge T, PAUSED lasts exactly q*QUANTA_CYCLES cycles. tx_pause_req and pause_active fall at edge T + q*QUANTA_CYCLES.
- Arithmetic: the timer never wraps; the max q=2^CNT_W-1 is supported. quanta_remaining = timer register.

Test Plan:
- Good PAUSE, q=3, ack 2 cycles after req → req high 1 cycle after good; PAUSED exactly 24 cycles; quanta_remaining steps 3,2,1,0 every 8 cycles; one pause_cnt_inc pulse.
- PAUSE with bad_frame_get (also good+bad in the same cycle) → tx_pause_req stays 0; no pause_cnt_inc.
- In PAUSED with quanta_remaining=2, a good PAUSE with q=0 (XON) → IDLE next edge, req=0; the same with q=5 → timer reloads to 5 and a full 40-cycle pause restarts.
- pause_quanta_vld with no pending frame, then good_frame_get → no effect; pause_frame and good_frame_get in the same cycle → prior frame resolved, new frame still pending.
- q=0xFFFF, then deassert pause_enable mid-pause → IDLE, all outputs 0 next edge; assert reset asynchronously during REQ → req drops without a clock edge.
- QUANTA_CYCLES=2, q=1 → PAUSED lasts exactly 2 cycles after ack.
